// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters (loader, fetch, data)
// and the single-port memory. slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_rvalid;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              core_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output ld_gnt, ld_rvalid, if_gnt, if_rvalid, dm_gnt, dm_rvalid,
    output rdata, core_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  ld_gnt, ld_rvalid, if_gnt, if_rvalid, dm_gnt, dm_rvalid,
    input  rdata, core_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way arbiter onto one single-port memory: loader has absolute priority,
// fetch and data share round-robin. Each access is IDLE/RESP -> ISSUE -> RESP.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic [1:0] {SRC_LD, SRC_IF, SRC_DM} src_e;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rr_q, rr_d;

  logic ld_elig, if_elig, dm_elig, pick;
  src_e pick_src;

  // The requester just served is excluded at the RESP-exit decision.
  always_comb begin
    ld_elig = bus.ld_req;
    if_elig = bus.if_req && !bus.ld_lock;
    dm_elig = bus.dm_req && !bus.ld_lock;
    if (state_q == RESP) begin
      case (src_q)
        SRC_LD:  ld_elig = 1'b0;
        SRC_IF:  if_elig = 1'b0;
        default: dm_elig = 1'b0;
      endcase
    end
    pick = ld_elig || if_elig || dm_elig;
    if (ld_elig)                 pick_src = SRC_LD;
    else if (if_elig && dm_elig) pick_src = rr_q ? SRC_DM : SRC_IF;
    else if (if_elig)            pick_src = SRC_IF;
    else                         pick_src = SRC_DM;
  end

  // NOTE: every next-state and output gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rr_d          = rr_q;
    bus.ld_gnt    = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.ld_rvalid = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.rdata     = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    if (state_q != ISSUE) begin
      state_d = IDLE;
      if (pick) begin
        state_d = ISSUE;
        src_d   = pick_src;
        case (pick_src)
          SRC_LD: begin
            we_d    = bus.ld_we;
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
          end
          SRC_IF: begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wdata_d = '0;
            rr_d    = 1'b1;
          end
          default: begin
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            rr_d    = 1'b0;
          end
        endcase
      end
    end

    case (state_q)
      ISSUE: begin
        state_d       = RESP;
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.ld_gnt    = (src_q == SRC_LD);
        bus.if_gnt    = (src_q == SRC_IF);
        bus.dm_gnt    = (src_q == SRC_DM);
      end
      RESP: begin
        bus.rdata     = bus.mem_rdata;
        bus.ld_rvalid = (src_q == SRC_LD);
        bus.if_rvalid = (src_q == SRC_IF);
        bus.dm_rvalid = (src_q == SRC_DM);
      end
      default: ;
    endcase

    // Gated by rst_n so the stall output is also forced low during reset.
    bus.core_stall = rst_n && (bus.ld_lock ||
                               (bus.if_req && !bus.if_gnt) ||
                               (bus.dm_req && !bus.dm_gnt));
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= SRC_LD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rr_q    <= rr_d;
    end
  end

endmodule
